// File: rtl/spi_pkg.sv
// Shared definitions for both ends of the SPI link: byte width, idle MISO level
// and the two-state frame FSM encoding.
package spi_pkg;

    localparam int   SPI_BYTE_W    = 8;
    localparam logic SPI_IDLE_MISO = 1'b1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-bit synchronizer for asynchronous pad inputs. Level, rise and fall
// outputs are all registered and aligned to the same clk cycle.
module spi_sync_edge #(
    parameter int               WIDTH       = 3,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // NOTE: every flop here uses <= so all stages sample the pre-edge values;
    // blocking assignments would collapse the chain into a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= RESET_VAL;
            end
            r_level <= RESET_VAL;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_level <= r_chain[SYNC_STAGES-1];
            r_rise  <= r_chain[SYNC_STAGES-1] & ~r_level;
            r_fall  <= ~r_chain[SYNC_STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversampled SCLK/MOSI/CS, MSB-first byte shifting, a one-deep
// ready/valid TX holding register and single-cycle RX/underrun/frame-error strobes.
module spi_peripheral import spi_pkg::*; #(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spiClk,
    input  logic                  spiIn,
    input  logic                  spiCs_n,
    output logic                  spiOut,
    output logic                  spiOutEn,
    input  logic [SPI_BYTE_W-1:0] dataTx,
    input  logic                  txValid,
    output logic                  txReady,
    output logic [SPI_BYTE_W-1:0] dataRx,
    output logic                  rxValid,
    output logic                  txUnderrun,
    output logic                  frameError,
    output logic                  busy
);

    localparam int CNT_W = $clog2(SPI_BYTE_W);

    // Synchronizer bit order: {cs_n, mosi, sclk}; reset values cs_n=1, mosi=0, sclk=0.
    logic [2:0] w_level;
    logic [2:0] w_rise;
    logic [2:0] w_fall;

    spi_sync_edge #(
        .WIDTH      (3),
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (3'b100)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async({spiCs_n, spiIn, spiClk}),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_unused;

    assign w_sclk_rise = w_rise[0];
    assign w_sclk_fall = w_fall[0];
    assign w_mosi      = w_level[1];
    assign w_cs_rise   = w_rise[2];
    assign w_cs_fall   = w_fall[2];
    assign w_unused    = &{1'b0, w_level[0], w_level[2], w_rise[1], w_fall[1]};

    spi_state_e            r_state,          w_state_nxt;
    logic [SPI_BYTE_W-1:0] r_tx_shift,       w_tx_shift_nxt;
    logic [SPI_BYTE_W-1:0] r_rx_shift,       w_rx_shift_nxt;
    logic [CNT_W-1:0]      r_bit_cnt,        w_bit_cnt_nxt;
    logic                  r_reload_pending, w_reload_pending_nxt;
    logic [SPI_BYTE_W-1:0] r_hold,           w_hold_nxt;
    logic                  r_hold_full,      w_hold_full_nxt;
    logic [SPI_BYTE_W-1:0] r_data_rx,        w_data_rx_nxt;
    logic                  r_rx_valid,       w_rx_valid_nxt;
    logic                  r_tx_underrun,    w_tx_underrun_nxt;
    logic                  r_frame_error,    w_frame_error_nxt;
    logic                  r_spi_out,        w_spi_out_nxt;
    logic                  r_spi_out_en,     w_spi_out_en_nxt;
    logic                  w_load;

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt          = r_state;
        w_tx_shift_nxt       = r_tx_shift;
        w_rx_shift_nxt       = r_rx_shift;
        w_bit_cnt_nxt        = r_bit_cnt;
        w_reload_pending_nxt = r_reload_pending;
        w_hold_nxt           = r_hold;
        w_hold_full_nxt      = r_hold_full;
        w_data_rx_nxt        = r_data_rx;
        w_rx_valid_nxt       = 1'b0;
        w_tx_underrun_nxt    = 1'b0;
        w_frame_error_nxt    = 1'b0;
        w_load               = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt   = ACTIVE;
                    w_bit_cnt_nxt = '0;
                    w_load        = 1'b1;
                end
            end
            ACTIVE: begin
                // CS release outranks any SCLK edge detected in the same cycle.
                if (w_cs_rise) begin
                    w_state_nxt          = IDLE;
                    w_frame_error_nxt    = (r_bit_cnt != '0);
                    w_bit_cnt_nxt        = '0;
                    w_rx_shift_nxt       = '0;
                    w_reload_pending_nxt = 1'b0;
                end else if (w_sclk_rise) begin
                    w_rx_shift_nxt = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
                    w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(SPI_BYTE_W - 1)) begin
                        w_data_rx_nxt        = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
                        w_rx_valid_nxt       = 1'b1;
                        w_reload_pending_nxt = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    if (r_reload_pending) begin
                        w_load               = 1'b1;
                        w_reload_pending_nxt = 1'b0;
                    end else begin
                        w_tx_shift_nxt = {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A load cycle consumes txValid as a bypass, so the hold register never
        // captures the same byte that is being shifted out.
        if (w_load) begin
            if (r_hold_full) begin
                w_tx_shift_nxt  = r_hold;
                w_hold_full_nxt = 1'b0;
            end else if (txValid) begin
                w_tx_shift_nxt = dataTx;
            end else begin
                w_tx_shift_nxt    = DEFAULT_TX;
                w_tx_underrun_nxt = 1'b1;
            end
        end else if (txValid && !r_hold_full) begin
            w_hold_nxt      = dataTx;
            w_hold_full_nxt = 1'b1;
        end

        w_spi_out_en_nxt = (w_state_nxt == ACTIVE);
        w_spi_out_nxt    = w_spi_out_en_nxt ? w_tx_shift_nxt[SPI_BYTE_W-1] : SPI_IDLE_MISO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_tx_shift       <= '0;
            r_rx_shift       <= '0;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b0;
            r_hold           <= '0;
            r_hold_full      <= 1'b0;
            r_data_rx        <= '0;
            r_rx_valid       <= 1'b0;
            r_tx_underrun    <= 1'b0;
            r_frame_error    <= 1'b0;
            r_spi_out        <= SPI_IDLE_MISO;
            r_spi_out_en     <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_tx_shift       <= w_tx_shift_nxt;
            r_rx_shift       <= w_rx_shift_nxt;
            r_bit_cnt        <= w_bit_cnt_nxt;
            r_reload_pending <= w_reload_pending_nxt;
            r_hold           <= w_hold_nxt;
            r_hold_full      <= w_hold_full_nxt;
            r_data_rx        <= w_data_rx_nxt;
            r_rx_valid       <= w_rx_valid_nxt;
            r_tx_underrun    <= w_tx_underrun_nxt;
            r_frame_error    <= w_frame_error_nxt;
            r_spi_out        <= w_spi_out_nxt;
            r_spi_out_en     <= w_spi_out_en_nxt;
        end
    end

    assign spiOut     = r_spi_out;
    assign spiOutEn   = r_spi_out_en;
    assign txReady    = ~r_hold_full;
    assign dataRx     = r_data_rx;
    assign rxValid    = r_rx_valid;
    assign txUnderrun = r_tx_underrun;
    assign frameError = r_frame_error;
    assign busy       = (r_state == ACTIVE);

endmodule
